// File: rtl/clock_pkg.sv
// Shared state encoding and default timing constants for the clock control block.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SET_HR  = 2'd1,
      ST_SET_MIN = 2'd2
   } state_e;

   localparam int DEF_DEB_CYCLES    = 20000;
   localparam int DEF_REPEAT_DELAY  = 6000000;
   localparam int DEF_REPEAT_PERIOD = 1500000;

   // MODE button walks RUN -> SET_HR -> SET_MIN -> RUN.
   function automatic state_e next_mode(input state_e s);
      case (s)
         ST_RUN:     next_mode = ST_SET_HR;
         ST_SET_HR:  next_mode = ST_SET_MIN;
         default:    next_mode = ST_RUN;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a one-cycle rise pulse.
module btn_debounce
   import clock_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          rise_q;
   logic          armed_q;
   logic [1:0]    fill_q;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) level_d = sync2_q;
         else                              cnt_d   = cnt_q + CW'(1);
      end
   end

   // armed_q stays low until the synchronised input is seen released after reset,
   // so a button held through reset cannot produce a press.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         armed_q <= 1'b0;
         fill_q  <= 2'd0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= level_d & ~level_q & armed_q;
         if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
         if (fill_q == 2'd2 && !sync2_q) armed_q <= 1'b1;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/clock_ctrl.sv
// Clock mode controller: RUN / SET_HR / SET_MIN with debounced buttons,
// SET auto-repeat, field blanking and seconds clear on return to RUN.
module clock_ctrl
   import clock_pkg::*;
#(
   parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tick,
   input  logic       i_btn_mode,
   input  logic       i_btn_set,
   input  logic       i_sec_carry,
   input  logic       i_min_carry,
   output logic       o_en_sec,
   output logic       o_en_min,
   output logic       o_en_hr,
   output logic       o_clr_sec,
   output logic [1:0] o_mode,
   output logic       o_blank_hr,
   output logic       o_blank_min
);

   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   state_e           state_q, state_d;
   logic             blink_q, blink_d;
   logic             clr_q, clr_d;
   logic             rep_act_q, rep_act_d;
   logic             rep_first_q, rep_first_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

   logic mode_rise, mode_level_unused;
   logic set_rise, set_level;
   logic in_set, mode_ev, set_ev, rep_pulse, adv;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .btn_i   (i_btn_mode),
      .level_o (mode_level_unused),
      .rise_o  (mode_rise)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .btn_i   (i_btn_set),
      .level_o (set_level),
      .rise_o  (set_rise)
   );

   // MODE has priority: a coincident SET press or repeat pulse is dropped.
   assign in_set    = (state_q != ST_RUN);
   assign mode_ev   = mode_rise;
   assign set_ev    = set_rise & ~mode_rise & in_set;
   assign rep_pulse = rep_act_q & set_level &
                      (rep_first_q ? (rep_cnt_q == REP_W'(REPEAT_DELAY))
                                   : (rep_cnt_q == REP_W'(REPEAT_PERIOD)));
   assign adv       = (set_ev | rep_pulse) & ~mode_ev;

   always_comb begin
      state_d     = state_q;
      blink_d     = blink_q;
      clr_d       = 1'b0;
      rep_act_d   = rep_act_q;
      rep_first_d = rep_first_q;
      rep_cnt_d   = rep_cnt_q + REP_W'(1);
      o_en_sec    = 1'b0;
      o_en_min    = 1'b0;
      o_en_hr     = 1'b0;

      if (mode_ev) state_d = next_mode(state_q);
      clr_d = mode_ev & (state_q == ST_SET_MIN);

      if (state_d != state_q || state_q == ST_RUN) blink_d = 1'b0;
      else if (i_tick)                             blink_d = ~blink_q;

      // Repeat counter holds cycles since the last press or repeat pulse.
      if (mode_ev || !set_level || !in_set) begin
         rep_act_d   = 1'b0;
         rep_first_d = 1'b1;
         rep_cnt_d   = '0;
      end else if (set_ev) begin
         rep_act_d   = 1'b1;
         rep_first_d = 1'b1;
         rep_cnt_d   = REP_W'(1);
      end else if (rep_pulse) begin
         rep_first_d = 1'b0;
         rep_cnt_d   = REP_W'(1);
      end else if (!rep_act_q) begin
         rep_cnt_d   = '0;
      end

      case (state_q)
         ST_RUN: begin
            o_en_sec = i_tick;
            o_en_min = i_sec_carry;
            o_en_hr  = i_min_carry;
         end
         ST_SET_HR:  o_en_hr  = adv;
         ST_SET_MIN: o_en_min = adv;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_RUN;
         blink_q     <= 1'b0;
         clr_q       <= 1'b0;
         rep_act_q   <= 1'b0;
         rep_first_q <= 1'b1;
         rep_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         blink_q     <= blink_d;
         clr_q       <= clr_d;
         rep_act_q   <= rep_act_d;
         rep_first_q <= rep_first_d;
         rep_cnt_q   <= rep_cnt_d;
      end
   end

   assign o_mode      = state_q;
   assign o_clr_sec   = clr_q;
   assign o_blank_hr  = (state_q == ST_SET_HR)  & blink_q;
   assign o_blank_min = (state_q == ST_SET_MIN) & blink_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl with short debounce and repeat timing.
module tb_clock_ctrl;

   localparam int DEB = 4;
   localparam int RD  = 20;
   localparam int RP  = 8;
   localparam int W   = 18;

   logic       clk = 1'b0;
   logic       rst, tick, btn_mode, btn_set, sec_carry, min_carry;
   logic       en_sec, en_min, en_hr, clr_sec, blank_hr, blank_min;
   logic [1:0] mode;

   clock_ctrl #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_tick      (tick),
      .i_btn_mode  (btn_mode),
      .i_btn_set   (btn_set),
      .i_sec_carry (sec_carry),
      .i_min_carry (min_carry),
      .o_en_sec    (en_sec),
      .o_en_min    (en_min),
      .o_en_hr     (en_hr),
      .o_clr_sec   (clr_sec),
      .o_mode      (mode),
      .o_blank_hr  (blank_hr),
      .o_blank_min (blank_min)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // ---------------- scoreboard ----------------
   // exp_q entries: {kind[1:0] = {hr,min}, offset from the press pulse[15:0]}
   logic [W-1:0] exp_q[$];
   int           obs_cyc_q[$];
   logic [1:0]   obs_kind_q[$];
   bit           sb_en = 1'b0;
   int           sec_cnt, clr_cnt, both_cnt, clr_cyc, mode_chg_cyc;
   logic [1:0]   prev_mode = 2'd0;

   always @(negedge clk) begin
      if (mode !== prev_mode) mode_chg_cyc = cyc;
      prev_mode = mode;
      if (sb_en) begin
         if (en_hr || en_min) begin
            obs_cyc_q.push_back(cyc);
            obs_kind_q.push_back({en_hr, en_min});
         end
         if (en_sec) sec_cnt++;
         if (en_hr && en_min) both_cnt++;
         if (clr_sec) begin
            clr_cnt++;
            clr_cyc = cyc;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sb_clear();
      exp_q.delete();
      obs_cyc_q.delete();
      obs_kind_q.delete();
      sec_cnt  = 0;
      clr_cnt  = 0;
      both_cnt = 0;
      clr_cyc  = -1;
   endtask

   task automatic do_reset();
      rst = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_set = 1'b0;
      sec_carry = 1'b0; min_carry = 1'b0;
      step(3);
      rst = 1'b0;
      step(1);
   endtask

   task automatic press_mode();
      btn_mode = 1'b1;
      step(DEB + 6);
      btn_mode = 1'b0;
      step(DEB + 6);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_set = 1'b0;
      sec_carry = 1'b0; min_carry = 1'b0;
      step(3);
      @(negedge clk);
      checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d want=0", mode); end
      checks++; if (clr_sec !== 1'b0) begin failures++; $display("FAIL reset_clr got=%b want=0", clr_sec); end
      checks++; if ({blank_hr, blank_min} !== 2'b00) begin failures++; $display("FAIL reset_blank got=%b want=00", {blank_hr, blank_min}); end
      checks++; if ({en_sec, en_min, en_hr} !== 3'b000) begin failures++; $display("FAIL reset_en got=%b want=000", {en_sec, en_min, en_hr}); end
      @(posedge clk); #1;
      rst = 1'b0;
      step(1);
   endtask

   task automatic test_run_enables();
      logic [2:0] p;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         p = (i == 0) ? 3'b111 : 3'($urandom_range(0, 7));
         {tick, sec_carry, min_carry} = p;
         @(negedge clk);
         checks++;
         if ({en_sec, en_min, en_hr} !== p) begin
            failures++; $display("FAIL run_en[%0d] got=%b want=%b", i, {en_sec, en_min, en_hr}, p);
         end
         checks++; if (mode !== 2'd0) begin failures++; $display("FAIL run_mode got=%0d want=0", mode); end
         @(posedge clk); #1;
         {tick, sec_carry, min_carry} = 3'b000;
         step(1);
      end
   endtask

   task automatic test_mode_cycle();
      logic [1:0] exp_mode [3];
      int         exp_clr  [3];
      exp_mode = '{2'd1, 2'd2, 2'd0};
      exp_clr  = '{0, 0, 1};
      do_reset();
      sb_clear();
      sb_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         press_mode();
         @(negedge clk);
         checks++; if (mode !== exp_mode[i]) begin failures++; $display("FAIL mode_seq[%0d] got=%0d want=%0d", i, mode, exp_mode[i]); end
         checks++; if (clr_cnt != exp_clr[i]) begin failures++; $display("FAIL clr_count[%0d] got=%0d want=%0d", i, clr_cnt, exp_clr[i]); end
         @(posedge clk); #1;
      end
      checks++; if (clr_cyc != mode_chg_cyc) begin failures++; $display("FAIL clr_timing got=%0d want=%0d", clr_cyc, mode_chg_cyc); end
      sb_en = 1'b0;
   endtask

   task automatic test_blink();
      do_reset();
      sb_clear();
      sb_en = 1'b1;
      press_mode();
      @(negedge clk);
      checks++; if (blank_hr !== 1'b0) begin failures++; $display("FAIL blink_entry got=%b want=0", blank_hr); end
      @(posedge clk); #1;
      tick = 1'b1; step(1); tick = 1'b0;
      @(negedge clk);
      checks++; if ({blank_hr, blank_min} !== 2'b10) begin failures++; $display("FAIL blink_tick1 got=%b want=10", {blank_hr, blank_min}); end
      @(posedge clk); #1;
      tick = 1'b1; step(1); tick = 1'b0;
      @(negedge clk);
      checks++; if (blank_hr !== 1'b0) begin failures++; $display("FAIL blink_tick2 got=%b want=0", blank_hr); end
      @(posedge clk); #1;
      tick = 1'b1; step(1); tick = 1'b0;
      press_mode();
      @(negedge clk);
      checks++; if ({blank_hr, blank_min} !== 2'b00) begin failures++; $display("FAIL blink_change got=%b want=00", {blank_hr, blank_min}); end
      @(posedge clk); #1;
      tick = 1'b1; step(1); tick = 1'b0;
      @(negedge clk);
      checks++; if ({blank_hr, blank_min} !== 2'b01) begin failures++; $display("FAIL blink_min got=%b want=01", {blank_hr, blank_min}); end
      checks++; if (sec_cnt != 0) begin failures++; $display("FAIL set_tick_sec got=%0d want=0", sec_cnt); end
      @(posedge clk); #1;
      press_mode();
      tick = 1'b1; step(1); tick = 1'b0;
      @(negedge clk);
      checks++; if ({blank_hr, blank_min} !== 2'b00) begin failures++; $display("FAIL blink_run got=%b want=00", {blank_hr, blank_min}); end
      @(posedge clk); #1;
      sb_en = 1'b0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      press_mode();
      sb_clear();
      sb_en = 1'b1;
      btn_mode = 1'b1; btn_set = 1'b1;
      step(DEB + 6);
      btn_mode = 1'b0; btn_set = 1'b0;
      step(DEB + 6);
      for (int i = 0; i < 3; i++) begin
         tick = 1'b1; step(1); tick = 1'b0; step(3);
      end
      @(negedge clk);
      checks++; if (mode !== 2'd2) begin failures++; $display("FAIL simul_mode got=%0d want=2", mode); end
      checks++; if (obs_cyc_q.size() != 0) begin failures++; $display("FAIL simul_pulses got=%0d want=0", obs_cyc_q.size()); end
      checks++; if (sec_cnt != 0) begin failures++; $display("FAIL simul_sec got=%0d want=0", sec_cnt); end
      @(posedge clk); #1;
      sb_en = 1'b0;
   endtask

   task automatic test_auto_repeat();
      int         t0, press, n_exp;
      logic [W-1:0] e;
      do_reset();
      press_mode();
      press_mode();
      sb_clear();
      exp_q.push_back({2'b01, 16'd0});
      exp_q.push_back({2'b01, 16'(RD)});
      exp_q.push_back({2'b01, 16'(RD + RP)});
      exp_q.push_back({2'b01, 16'(RD + 2 * RP)});
      n_exp = exp_q.size();
      sb_en = 1'b1;
      btn_set = 1'b1;
      t0 = cyc;
      step(40);
      btn_set = 1'b0;
      step(DEB + 12);
      sb_en = 1'b0;
      checks++; if (obs_cyc_q.size() != n_exp) begin failures++; $display("FAIL repeat_count got=%0d want=%0d", obs_cyc_q.size(), n_exp); end
      press = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1;
      checks++;
      if (press < t0 + 2 + DEB || press > t0 + 4 + DEB) begin
         failures++; $display("FAIL repeat_press_latency got=%0d want=%0d..%0d", press - t0, 2 + DEB, 4 + DEB);
      end
      while (exp_q.size() > 0 && obs_cyc_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_kind_q[0] !== e[17:16] || (obs_cyc_q[0] - press) != int'(e[15:0])) begin
            failures++; $display("FAIL repeat_pulse got=kind%b@+%0d want=kind%b@+%0d",
                                 obs_kind_q[0], obs_cyc_q[0] - press, e[17:16], e[15:0]);
         end
         void'(obs_cyc_q.pop_front());
         void'(obs_kind_q.pop_front());
      end
      checks++; if (both_cnt != 0) begin failures++; $display("FAIL repeat_both got=%0d want=0", both_cnt); end
   endtask

   task automatic test_bounce();
      int t1;
      do_reset();
      press_mode();
      sb_clear();
      exp_q.push_back({2'b10, 16'd0});
      sb_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         btn_set = ((i / 2) % 2 == 0);
         step(1);
      end
      btn_set = 1'b1;
      t1 = cyc;
      step(12);
      btn_set = 1'b0;
      step(DEB + 12);
      sb_en = 1'b0;
      checks++; if (obs_cyc_q.size() != exp_q.size()) begin failures++; $display("FAIL bounce_count got=%0d want=%0d", obs_cyc_q.size(), exp_q.size()); end
      if (obs_cyc_q.size() > 0) begin
         checks++;
         if (obs_kind_q[0] !== exp_q[0][17:16] || obs_cyc_q[0] < t1 + 2 + DEB || obs_cyc_q[0] > t1 + 4 + DEB) begin
            failures++; $display("FAIL bounce_pulse got=kind%b@+%0d want=kind%b@+%0d..%0d",
                                 obs_kind_q[0], obs_cyc_q[0] - t1, exp_q[0][17:16], 2 + DEB, 4 + DEB);
         end
      end
   endtask

   task automatic test_reset_mid_repeat();
      do_reset();
      press_mode();
      press_mode();
      btn_set = 1'b1;
      step(DEB + 6 + 24);
      rst = 1'b1;
      step(1);
      @(negedge clk);
      checks++; if (mode !== 2'd0) begin failures++; $display("FAIL rst_mid_mode got=%0d want=0", mode); end
      @(posedge clk); #1;
      rst = 1'b0;
      sb_clear();
      sb_en = 1'b1;
      step(40);
      @(negedge clk);
      checks++; if (mode !== 2'd0) begin failures++; $display("FAIL rst_hold_mode got=%0d want=0", mode); end
      checks++; if (obs_cyc_q.size() != 0) begin failures++; $display("FAIL rst_hold_en got=%0d want=0", obs_cyc_q.size()); end
      checks++; if (clr_cnt != 0) begin failures++; $display("FAIL rst_clr got=%0d want=0", clr_cnt); end
      @(posedge clk); #1;
      press_mode();
      step(30);
      @(negedge clk);
      checks++; if (mode !== 2'd1) begin failures++; $display("FAIL rst_held_set_mode got=%0d want=1", mode); end
      checks++; if (obs_cyc_q.size() != 0) begin failures++; $display("FAIL rst_held_set_event got=%0d want=0", obs_cyc_q.size()); end
      @(posedge clk); #1;
      btn_set = 1'b0;
      step(DEB + 6);
      sb_en = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_run_enables();
      test_mode_cycle();
      test_blink();
      test_simultaneous();
      test_auto_repeat();
      test_bounce();
      test_reset_mid_repeat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/clock_ctrl.md
CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 20000: clock cycles a synchronised button must stay stable before its debounced level changes.
REQ-002 SHALL have parameter REPEAT_DELAY, default 6000000: cycles the SET button is held before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 1500000: cycles between auto-repeat pulses.
REQ-004 i_clk  in  1  system clock, all logic posedge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_tick  in  1  one-cycle 1 Hz pulse.
REQ-007 i_btn_mode  in  1  raw asynchronous MODE button, high = pressed.
REQ-008 i_btn_set  in  1  raw asynchronous SET button, high = pressed.
REQ-009 i_sec_carry  in  1  carry from the seconds BCD counter, already gated by its enable.
REQ-010 i_min_carry  in  1  carry from the minutes BCD counter, already gated by its enable.
REQ-011 o_en_sec  out  1  seconds counter enable.
REQ-012 o_en_min  out  1  minutes counter enable.
REQ-013 o_en_hr  out  1  hours counter enable.
REQ-014 o_clr_sec  out  1  seconds counter synchronous clear.
REQ-015 o_mode  out  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN.
REQ-016 o_blank_hr / o_blank_min  out  1 each  display blanking for the field being set.

Function
REQ-017 Each button SHALL pass a 2-flop synchroniser, then a stability counter; debounced level updates only after DEB_CYCLES consecutive equal samples.
REQ-018 A press event SHALL be a one-cycle pulse on the debounced rising edge, asserted 2+DEB_CYCLES to 4+DEB_CYCLES cycles after the raw input rises and stays high.
REQ-019 States SHALL be RUN, SET_HR, SET_MIN; a MODE press advances RUN->SET_HR->SET_MIN->RUN; no other transitions except reset.
REQ-020 In RUN: o_en_sec = i_tick, o_en_min = i_sec_carry, o_en_hr = i_min_carry, all combinational; SET presses ignored.
REQ-021 In SET_HR: o_en_sec = o_en_min = 0; o_en_hr = 1 for exactly one cycle per SET press or auto-repeat pulse; i_min_carry ignored.
REQ-022 In SET_MIN: o_en_sec = o_en_hr = 0; o_en_min = one cycle per SET press or repeat pulse; i_sec_carry ignored; no hour roll-over from setting.
REQ-023 Auto-repeat: while debounced SET stays high in a set state, first repeat pulse REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles; the repeat counter clears on release or state change.
REQ-024 On the SET_MIN->RUN transition o_clr_sec SHALL pulse high for exactly one cycle (the cycle after the MODE press); otherwise 0.
REQ-025 A blink flag SHALL toggle on each i_tick in set states, forced 0 in RUN and on every state change; o_blank_hr = SET_HR & blink, o_blank_min = SET_MIN & blink.
REQ-026 Simultaneous MODE and SET press events: MODE wins, SET event discarded, no enable pulse.
REQ-027 At most one of o_en_hr / o_en_min SHALL pulse in any set-state cycle; i_tick in set states never advances seconds.

Reset
REQ-028 i_rst SHALL force state RUN, blink 0, synchronisers, debounced levels and all counters 0; o_mode=0, o_clr_sec=0, o_blank_*=0 in the cycle after reset.
REQ-029 Reset asserted mid-operation (including mid-debounce or mid-repeat) SHALL take priority over all events in that cycle; a button held through reset requires release and re-press to generate an event.

Structure
REQ-030 Shared package clock_pkg SHALL hold the state encoding and the default parameter constants.
REQ-031 A sub-module btn_debounce (synchroniser, stability counter, rise pulse) SHALL be instantiated once per button.

Verification (DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-032 RUN, i_tick with i_sec_carry=1, i_min_carry=1 in the same cycle -> o_en_sec=o_en_min=o_en_hr=1 that cycle, o_mode=0.
REQ-033 Three clean MODE presses -> o_mode 1, 2, 0; one-cycle o_clr_sec only after the third.
REQ-034 SET_HR, MODE and SET pressed in the same cycle, 3 ticks -> o_mode=2, no o_en_hr, o_en_sec stays 0.
REQ-035 SET_MIN, SET held 40 cycles -> o_en_min pulses at press, press+20, press+28, press+36; none after release.
REQ-036 SET_HR, SET bounced 0/1 every 2 cycles for 20 cycles then held high -> exactly one o_en_hr pulse.
REQ-037 SET_MIN, i_rst mid-repeat -> o_mode=0, no o_en_min, no o_clr_sec; still-held SET produces no event.
